// File: rtl/typhoon_pkg.sv
// Shared types and widths for the tile scheduler and its offset walker.
package typhoon_pkg;
  localparam int OFFSET_W = 10;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RELEASE, DRAIN} raster_state_t;
  typedef enum logic {WB_IDLE, WB_ACTIVE} wb_state_t;
endpackage

// File: rtl/tile_walker.sv
// Screen-order tile origin counters: clear to (0,0), step one tile right,
// wrapping to the next tile row at the right screen edge.
module tile_walker
  import typhoon_pkg::*;
#(
  parameter int tileDim = 8,
  parameter int screenW = 640,
  parameter int screenH = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                step,
  output logic [OFFSET_W-1:0] x,
  output logic [OFFSET_W-1:0] y,
  output logic                last
);
  localparam logic [OFFSET_W-1:0] STEP   = OFFSET_W'(tileDim);
  localparam logic [OFFSET_W-1:0] WIDTH  = OFFSET_W'(screenW);
  localparam logic [OFFSET_W-1:0] LAST_X = OFFSET_W'(screenW - tileDim);
  localparam logic [OFFSET_W-1:0] LAST_Y = OFFSET_W'(screenH - tileDim);

  logic [OFFSET_W-1:0] x_nxt;

  assign x_nxt = x + STEP;
  assign last  = (x == LAST_X) && (y == LAST_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_nxt == WIDTH) begin
        x <= '0;
        y <= y + STEP;
      end else begin
        x <= x_nxt;
      end
    end
  end
endmodule

// File: rtl/tile_scheduler.sv
// Frame sequencer: issues tiles to the rasterizer over two ping-pong color
// buffers and drains each filled buffer to writeback in raster order.
module tile_scheduler
  import typhoon_pkg::*;
#(
  parameter int tileDim = 8,
  parameter int screenW = 640,
  parameter int screenH = 480
) (
  input  logic                BOARD_CLK,
  input  logic                BOARD_RESET_N,
  input  logic                startFrame,
  output logic                frameDone,
  output logic                startRasterizing,
  input  logic                doneRasterizing,
  output logic                rasterTileID,
  output logic [OFFSET_W-1:0] rasterxOffset,
  output logic [OFFSET_W-1:0] rasteryOffset,
  output logic                writebackStart,
  input  logic                writebackDone,
  output logic                writebackTileID,
  output logic [OFFSET_W-1:0] writebackxOffset,
  output logic [OFFSET_W-1:0] writebackyOffset,
  output logic                busy
);
  raster_state_t             state;
  wb_state_t                 wb_state;
  logic [1:0]                buf_full;
  logic [1:0][OFFSET_W-1:0]  buf_x;
  logic [1:0][OFFSET_W-1:0]  buf_y;
  logic                      wb_next;
  logic                      walk_clear, walk_step, last_tile;
  logic                      buf_set, buf_clr;

  assign walk_clear = (state == IDLE) && startFrame;
  assign walk_step  = (state == RELEASE) && !doneRasterizing && !last_tile;
  assign buf_set    = (state == BUSY) && doneRasterizing;
  assign buf_clr    = (wb_state == WB_ACTIVE) && writebackDone;

  tile_walker #(.tileDim(tileDim), .screenW(screenW), .screenH(screenH)) u_walker (
    .clk   (BOARD_CLK),
    .rst_n (BOARD_RESET_N),
    .clear (walk_clear),
    .step  (walk_step),
    .x     (rasterxOffset),
    .y     (rasteryOffset),
    .last  (last_tile)
  );

  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      state            <= IDLE;
      startRasterizing <= 1'b0;
      rasterTileID     <= 1'b0;
      frameDone        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state)
        IDLE: if (startFrame) begin
          rasterTileID <= 1'b0;
          busy         <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: if (!buf_full[rasterTileID] && !doneRasterizing) begin
          startRasterizing <= 1'b1;
          state            <= BUSY;
        end
        BUSY: if (doneRasterizing) begin
          startRasterizing <= 1'b0;
          state            <= RELEASE;
        end
        RELEASE: if (!doneRasterizing) begin
          if (last_tile) state <= DRAIN;
          else begin
            rasterTileID <= ~rasterTileID;
            state        <= ISSUE;
          end
        end
        DRAIN: if (buf_full == 2'b00 && !writebackStart) begin
          frameDone <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raster sets and writeback clears always target different buffers.
  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      buf_full <= '0;
      buf_x    <= '0;
      buf_y    <= '0;
    end else begin
      if (buf_set) begin
        buf_full[rasterTileID] <= 1'b1;
        buf_x[rasterTileID]    <= rasterxOffset;
        buf_y[rasterTileID]    <= rasteryOffset;
      end
      if (buf_clr) buf_full[wb_next] <= 1'b0;
    end
  end

  always_ff @(posedge BOARD_CLK or negedge BOARD_RESET_N) begin
    if (!BOARD_RESET_N) begin
      wb_state         <= WB_IDLE;
      writebackStart   <= 1'b0;
      writebackTileID  <= 1'b0;
      writebackxOffset <= '0;
      writebackyOffset <= '0;
      wb_next          <= 1'b0;
    end else begin
      case (wb_state)
        WB_IDLE: if (buf_full[wb_next]) begin
          writebackTileID  <= wb_next;
          writebackxOffset <= buf_x[wb_next];
          writebackyOffset <= buf_y[wb_next];
          writebackStart   <= 1'b1;
          wb_state         <= WB_ACTIVE;
        end else if (walk_clear) begin
          wb_next <= 1'b0;
        end
        WB_ACTIVE: if (writebackDone) begin
          writebackStart <= 1'b0;
          wb_next        <= ~wb_next;
          wb_state       <= WB_IDLE;
        end
        default: wb_state <= WB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench: 16x16 screen for protocol/corner cases, 640x480 in parallel.
module tb_tile_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start_frame = 1'b0;
  logic frame_done, start_rast, rast_id, wb_start, wb_id, busy;
  logic [9:0] rx_off, ry_off, wx_off, wy_off;
  logic done_rast, wb_done;
  logic auto_r = 1'b1, auto_w = 1'b1, m_rd = 1'b0, m_wd = 1'b0;
  logic mod_rd = 1'b0, mod_wd = 1'b0;
  int   rc = 0, wc = 0, wb_lat = 3;

  logic rst2_n = 1'b0, sf2 = 1'b0;
  logic fd2, sr2, id2, ws2, wid2, busy2, rd2 = 1'b0, wd2 = 1'b0;
  logic [9:0] x2, y2, wx2, wy2;
  int   rc2 = 0, wc2 = 0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign done_rast = auto_r ? mod_rd : m_rd;
  assign wb_done   = auto_w ? mod_wd : m_wd;

  tile_scheduler #(.tileDim(8), .screenW(16), .screenH(16)) u_dut (
    .BOARD_CLK(clk), .BOARD_RESET_N(rst_n), .startFrame(start_frame),
    .frameDone(frame_done), .startRasterizing(start_rast), .doneRasterizing(done_rast),
    .rasterTileID(rast_id), .rasterxOffset(rx_off), .rasteryOffset(ry_off),
    .writebackStart(wb_start), .writebackDone(wb_done), .writebackTileID(wb_id),
    .writebackxOffset(wx_off), .writebackyOffset(wy_off), .busy(busy)
  );

  tile_scheduler u_big (
    .BOARD_CLK(clk), .BOARD_RESET_N(rst2_n), .startFrame(sf2),
    .frameDone(fd2), .startRasterizing(sr2), .doneRasterizing(rd2),
    .rasterTileID(id2), .rasterxOffset(x2), .rasteryOffset(y2),
    .writebackStart(ws2), .writebackDone(wd2), .writebackTileID(wid2),
    .writebackxOffset(wx2), .writebackyOffset(wy2), .busy(busy2)
  );

  // Rasterizer: done ~5 cycles after start, held until start drops.
  // Copier: one-cycle done pulse wb_lat cycles after request.
  always @(negedge clk) begin
    if (start_rast) begin if (rc >= 4) mod_rd = 1'b1; else rc++; end
    else begin mod_rd = 1'b0; rc = 0; end
    if (mod_wd) mod_wd = 1'b0;
    else if (wb_start) begin wc++; if (wc >= wb_lat) begin mod_wd = 1'b1; wc = 0; end end
    else wc = 0;
    if (sr2) begin if (rc2 >= 4) rd2 = 1'b1; else rc2++; end
    else begin rd2 = 1'b0; rc2 = 0; end
    if (wd2) wd2 = 1'b0;
    else if (ws2) begin wc2++; if (wc2 >= 3) begin wd2 = 1'b1; wc2 = 0; end end
    else wc2 = 0;
  end

  logic sr_q = 1'b0, ws_q = 1'b0, sr2_q = 1'b0, ws2_q = 1'b0;
  int rn = 0, wn = 0, fd_cnt = 0, rise2 = 0, fd2_cnt = 0;
  logic [9:0] lx[64], ly[64], lwx[64], lwy[64];
  logic       lid[64], lwid[64];
  logic [9:0] lx2 = '0, ly2 = '0, lwx2 = '0, lwy2 = '0;
  logic       lid2 = 1'b0, lwid2 = 1'b0;

  always @(negedge clk) begin
    if (start_rast && !sr_q && rn < 64) begin
      lx[rn] = rx_off; ly[rn] = ry_off; lid[rn] = rast_id; rn++;
    end
    if (wb_start && !ws_q && wn < 64) begin
      lwx[wn] = wx_off; lwy[wn] = wy_off; lwid[wn] = wb_id; wn++;
    end
    if (frame_done) fd_cnt++;
    sr_q = start_rast; ws_q = wb_start;
    if (sr2 && !sr2_q) begin rise2++; lx2 = x2; ly2 = y2; lid2 = id2; end
    if (ws2 && !ws2_q) begin lwx2 = wx2; lwy2 = wy2; lwid2 = wid2; end
    if (fd2) fd2_cnt++;
    sr2_q = sr2; ws2_q = ws2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_frame = 1'b1; step(); start_frame = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int lim);
    int i = 0;
    while (!frame_done && i < lim) begin step(); i++; end
    chk(tag, frame_done, 1);
  endtask

  // Expected 2x2 walk: (0,0)/0, (8,0)/1, (0,8)/0, (8,8)/1 for raster and writeback.
  task automatic chk_seq(input string tag, input int rb, input int wb);
    chk({tag, "_rcnt"}, rn - rb, 4);
    chk({tag, "_wcnt"}, wn - wb, 4);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_rtile"}, {lx[rb+k], ly[rb+k], lid[rb+k]},
          {10'((k % 2) * 8), 10'((k / 2) * 8), 1'(k % 2)});
      chk({tag, "_wtile"}, {lwx[wb+k], lwy[wb+k], lwid[wb+k]},
          {10'((k % 2) * 8), 10'((k / 2) * 8), 1'(k % 2)});
    end
  endtask

  initial begin
    int rb, wbb, f0, n;
    repeat (3) step();
    chk("rst_outs", {frame_done, start_rast, rast_id, rx_off, ry_off, wb_start, wb_id,
                     wx_off, wy_off, busy}, 0);
    chk("rst_big", {fd2, sr2, ws2, busy2}, 0);
    rst_n = 1'b1; rst2_n = 1'b1; step();
    sf2 = 1'b1; step(); sf2 = 1'b0;

    // Basic frame with exact startup latency.
    rb = rn; wbb = wn; f0 = fd_cnt;
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_sr_early", start_rast, 0);
    step();
    chk("t1_first_issue", {start_rast, rast_id, rx_off, ry_off}, {1'b1, 1'b0, 20'd0});
    wait_fd("t1_fd", 300);
    chk("t1_busy_fall", busy, 0);
    step();
    chk("t1_fd_width", frame_done, 0);
    repeat (5) step();
    chk("t1_fd_count", fd_cnt - f0, 1);
    chk_seq("t1", rb, wbb);

    // Copier stall blocks buffer 0 reuse.
    wb_lat = 100; rb = rn; wbb = wn; f0 = fd_cnt;
    pulse_start();
    repeat (60) step();
    chk("t2_two_tiles", rn - rb, 2);
    chk("t2_stalled", {start_rast, rast_id, rx_off, ry_off}, {1'b0, 1'b0, 10'd0, 10'd8});
    n = 0;
    do begin @(posedge clk); n++; end while (!wb_done && n < 200);
    chk("t2_wbdone_seen", wb_done, 1);
    #1;
    chk("t2_after_M", {start_rast, wb_start}, 0);
    wb_lat = 3;
    step();
    chk("t2_after_M1", {start_rast, rast_id, rx_off, ry_off}, {1'b1, 1'b0, 10'd0, 10'd8});
    wait_fd("t2_fd", 300);
    repeat (5) step();
    chk("t2_fd_count", fd_cnt - f0, 1);
    chk_seq("t2", rb, wbb);

    // Reset while rasterizing tile (8,0).
    f0 = fd_cnt;
    pulse_start();
    n = 0;
    while (!(start_rast && rx_off == 10'd8) && n < 100) begin step(); n++; end
    chk("t3_reach", {start_rast, rx_off}, {1'b1, 10'd8});
    rst_n = 1'b0; #1;
    chk("t3_rst_outs", {frame_done, start_rast, rast_id, rx_off, ry_off, wb_start, wb_id,
                        wx_off, wy_off, busy}, 0);
    repeat (5) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t3_no_fd", fd_cnt - f0, 0);
    chk("t3_idle", {busy, start_rast, wb_start}, 0);
    rb = rn; wbb = wn; f0 = fd_cnt;
    pulse_start();
    step();
    chk("t3_restart", {start_rast, rast_id, rx_off, ry_off}, {1'b1, 1'b0, 20'd0});
    wait_fd("t3_fd", 300);
    repeat (5) step();
    chk("t3_fd_count", fd_cnt - f0, 1);
    chk_seq("t3", rb, wbb);

    // startFrame mid-frame is ignored.
    rb = rn; wbb = wn; f0 = fd_cnt;
    pulse_start();
    repeat (12) step();
    chk("t4_busy_mid", busy, 1);
    pulse_start();
    wait_fd("t4_fd", 300);
    repeat (10) step();
    chk("t4_fd_count", fd_cnt - f0, 1);
    chk("t4_idle", busy, 0);
    chk_seq("t4", rb, wbb);

    // Writeback of buffer 0 completes in the cycle raster finishes buffer 1.
    auto_r = 1'b0; auto_w = 1'b0; rb = rn; wbb = wn; f0 = fd_cnt;
    pulse_start();
    step();
    chk("t5_issue0", {start_rast, rast_id}, {1'b1, 1'b0});
    m_rd = 1'b1; step();
    chk("t5_done0", start_rast, 0);
    m_rd = 1'b0; step();
    chk("t5_wb0", {wb_start, wb_id, wx_off, wy_off}, {1'b1, 1'b0, 20'd0});
    step();
    chk("t5_issue1", {start_rast, rast_id, rx_off, ry_off}, {1'b1, 1'b1, 10'd8, 10'd0});
    m_rd = 1'b1; m_wd = 1'b1; step();
    chk("t5_same_edge", {start_rast, wb_start}, 0);
    m_rd = 1'b0; m_wd = 1'b0; step();
    chk("t5_wb1", {wb_start, wb_id, wx_off, wy_off}, {1'b1, 1'b1, 10'd8, 10'd0});
    chk("t5_adv", {rast_id, rx_off, ry_off}, {1'b0, 10'd0, 10'd8});
    step();
    chk("t5_issue2_nostall", start_rast, 1);
    auto_r = 1'b1; auto_w = 1'b1;
    wait_fd("t5_fd", 300);
    repeat (5) step();
    chk("t5_fd_count", fd_cnt - f0, 1);
    chk_seq("t5", rb, wbb);

    // Full 640x480 frame running alongside the directed tests.
    n = 0;
    while (fd2_cnt == 0 && n < 60000) begin step(); n++; end
    repeat (5) step();
    chk("big_fd_count", fd2_cnt, 1);
    chk("big_tiles", rise2, 4800);
    chk("big_last_raster", {lx2, ly2, lid2}, {10'd632, 10'd472, 1'b1});
    chk("big_last_wb", {lwx2, lwy2, lwid2}, {10'd632, 10'd472, 1'b1});
    chk("big_idle", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
